// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter that serialises read/write commands onto a
// single-port RAM and routes read data back to the requester that issued it.
module ram_arbiter #(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_din,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_din,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  output logic          busy,

  output logic          ram_start,
  output logic          ram_we,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [2:0] LatCnt = 3'(RD_LAT);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRdWait
  } state_e;

  state_e        state_q;
  logic          ptr_q;
  logic [2:0]    cnt_q;
  logic          win_q;
  logic          cmd_we_q;
  logic          ram_start_q;
  logic          ram_we_q;
  logic [AW-1:0] ram_adr_q;
  logic [DW-1:0] ram_din_q;
  logic          m0_rvalid_q;
  logic          m1_rvalid_q;
  logic [DW-1:0] m0_rdata_q;
  logic [DW-1:0] m1_rdata_q;

  logic          grant;
  logic          win;

  // The pointer only matters on a tie; a lone requester always wins.
  always_comb begin
    grant = (state_q == StIdle) && !rst && (m0_req || m1_req);
    if (m0_req && m1_req) begin
      win = ptr_q;
    end else begin
      win = m1_req;
    end
    m0_gnt = grant && !win;
    m1_gnt = grant && win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      cnt_q       <= 3'd0;
      win_q       <= 1'b0;
      cmd_we_q    <= 1'b0;
      ram_start_q <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_adr_q   <= '0;
      ram_din_q   <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      ram_start_q <= 1'b0;
      ram_we_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            // The RAM strobe is loaded here so it is registered for the ISSUE cycle.
            win_q       <= win;
            ptr_q       <= ~win;
            cmd_we_q    <= win ? m1_we : m0_we;
            ram_start_q <= 1'b1;
            ram_we_q    <= win ? m1_we : m0_we;
            ram_adr_q   <= win ? m1_adr : m0_adr;
            ram_din_q   <= win ? m1_din : m0_din;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (cmd_we_q) begin
            state_q <= StIdle;
          end else begin
            cnt_q   <= LatCnt;
            state_q <= StRdWait;
          end
        end
        StRdWait: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            if (win_q) begin
              m1_rdata_q  <= ram_dout;
              m1_rvalid_q <= 1'b1;
            end else begin
              m0_rdata_q  <= ram_dout;
              m0_rvalid_q <= 1'b1;
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign ram_start = ram_start_q;
  assign ram_we    = ram_we_q;
  assign ram_adr   = ram_adr_q;
  assign ram_din   = ram_din_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a cycle-scheduled transaction model checks the RD_LAT=1 instance
// every cycle; a second RD_LAT=3 instance gets hand-computed timing checks.
module tb_ram_arbiter;

  localparam int LAT  = 1;
  localparam int LATB = 3;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // DUT a (RD_LAT=1)
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [7:0]  m0_adr, m1_adr;
  logic [31:0] m0_din, m1_din;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, busy;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_start, ram_we;
  logic [7:0]  ram_adr;
  logic [31:0] ram_din, ram_dout;

  ram_arbiter #(.AW(8), .DW(32), .RD_LAT(LAT)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_din(m0_din),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_din(m1_din),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .busy(busy),
    .ram_start(ram_start), .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // DUT b (RD_LAT=3)
  logic        rst_b;
  logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [7:0]  b_m0_adr, b_m1_adr;
  logic [31:0] b_m0_din, b_m1_din;
  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_busy;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_ram_start, b_ram_we;
  logic [7:0]  b_ram_adr;
  logic [31:0] b_ram_din, b_ram_dout;

  ram_arbiter #(.AW(8), .DW(32), .RD_LAT(LATB)) dut_b (
    .clk(clk), .rst(rst_b),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_adr(b_m0_adr), .m0_din(b_m0_din),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_adr(b_m1_adr), .m1_din(b_m1_din),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .busy(b_busy),
    .ram_start(b_ram_start), .ram_we(b_ram_we), .ram_adr(b_ram_adr), .ram_din(b_ram_din),
    .ram_dout(b_ram_dout)
  );

  // Behavioural RAMs: dout shows read data RD_LAT cycles after the start cycle.
  logic [31:0] mem_a [256];
  logic [31:0] pipe_a [LAT];
  always @(posedge clk) begin
    if (ram_start && ram_we) mem_a[ram_adr] <= ram_din;
    pipe_a[0] <= (ram_start && !ram_we) ? mem_a[ram_adr] : pipe_a[0];
    for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
  end
  assign ram_dout = pipe_a[LAT-1];

  logic [31:0] mem_b [256];
  logic [31:0] pipe_b [LATB];
  always @(posedge clk) begin
    if (b_ram_start && b_ram_we) mem_b[b_ram_adr] <= b_ram_din;
    pipe_b[0] <= (b_ram_start && !b_ram_we) ? mem_b[b_ram_adr] : pipe_b[0];
    for (int i = 1; i < LATB; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign b_ram_dout = pipe_b[LATB-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: per-cycle expected outputs scheduled at grant time.
  bit          e_start [MAXC];
  bit          e_we    [MAXC];
  bit          e_busy  [MAXC];
  bit          e_rv0   [MAXC];
  bit          e_rv1   [MAXC];
  logic [7:0]  e_adr   [MAXC];
  logic [31:0] e_din   [MAXC];
  logic [31:0] e_rd    [MAXC];
  logic [31:0] ref_mem [256];
  logic [31:0] mrd0 = '0, mrd1 = '0;
  int          free_at = 0;
  bit          mptr = 1'b0;

  always @(negedge clk) begin
    int c;
    bit w, g0, g1;
    logic xw;
    logic [7:0] xa;
    logic [31:0] xd;
    c = cyc;
    if (c < MAXC - 8) begin
      if (e_rv0[c]) mrd0 = e_rd[c];
      if (e_rv1[c]) mrd1 = e_rd[c];
      g0 = 1'b0;
      g1 = 1'b0;
      w  = 1'b0;
      if (!rst && c >= free_at && (m0_req || m1_req)) begin
        w  = (m0_req && m1_req) ? mptr : m1_req;
        g0 = !w;
        g1 = w;
      end
      if (chk_en) begin
        chk("m0_gnt", m0_gnt, g0);
        chk("m1_gnt", m1_gnt, g1);
        chk("ram_start", ram_start, e_start[c]);
        chk("ram_we", ram_we, e_we[c]);
        if (e_start[c]) chk("ram_adr", ram_adr, e_adr[c]);
        if (e_start[c] && e_we[c]) chk("ram_din", ram_din, e_din[c]);
        chk("busy", busy, e_busy[c]);
        chk("m0_rvalid", m0_rvalid, e_rv0[c]);
        chk("m1_rvalid", m1_rvalid, e_rv1[c]);
        chk("m0_rdata", m0_rdata, mrd0);
        chk("m1_rdata", m1_rdata, mrd1);
      end
      if (rst) begin
        for (int k = c + 1; k < c + 8; k++) begin
          e_start[k] = 0; e_we[k] = 0; e_busy[k] = 0; e_rv0[k] = 0; e_rv1[k] = 0;
        end
        mrd0 = '0;
        mrd1 = '0;
        free_at = c + 1;
        mptr = 1'b0;
      end else if (g0 || g1) begin
        xw = w ? m1_we : m0_we;
        xa = w ? m1_adr : m0_adr;
        xd = w ? m1_din : m0_din;
        e_start[c+1] = 1; e_we[c+1] = xw; e_adr[c+1] = xa; e_din[c+1] = xd;
        mptr = !w;
        if (xw) begin
          ref_mem[xa] = xd;
          free_at = c + 2;
          e_busy[c+1] = 1;
        end else begin
          free_at = c + 2 + LAT;
          for (int k = c + 1; k <= c + 1 + LAT; k++) e_busy[k] = 1;
          if (w) e_rv1[c+2+LAT] = 1; else e_rv0[c+2+LAT] = 1;
          e_rd[c+2+LAT] = ref_mem[xa];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) tick();
    @(negedge clk);
  endtask

  task automatic drive(input int who, input logic rq, input logic we, input logic [7:0] a,
                       input logic [31:0] d);
    if (who == 0) begin
      m0_req = rq; m0_we = we; m0_adr = a; m0_din = d;
    end else begin
      m1_req = rq; m1_we = we; m1_adr = a; m1_din = d;
    end
  endtask

  // Raise a request, hold until granted, drop it the cycle after; g = grant cycle.
  task automatic request(input int who, input logic we, input logic [7:0] a,
                         input logic [31:0] d, output int g);
    bit got;
    got = 1'b0;
    g = -1;
    drive(who, 1'b1, we, a, d);
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if ((who == 0 && m0_gnt) || (who == 1 && m1_gnt)) begin
        got = 1'b1;
        g = cyc;
      end
      tick();
    end
    drive(who, 1'b0, we, a, d);
    chk("gnt_seen", got, 1);
  endtask

  int g, g2, gw, gr;

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    b_m0_req = 0; b_m0_we = 0; b_m0_adr = 0; b_m0_din = 0;
    b_m1_req = 0; b_m1_we = 0; b_m1_adr = 0; b_m1_din = 0;
    tick();
    tick();
    rst = 1'b0; rst_b = 1'b0;
    chk_en = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_ram_start", ram_start, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_adr", ram_adr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_b_busy", b_busy, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_start", ram_start, 0);
      chk("idle_busy", busy, 0);
    end

    // Both requesters hold writes through reset
    tick();
    drive(0, 1'b1, 1'b1, 8'h01, 32'h1);
    drive(1, 1'b1, 1'b1, 8'h02, 32'h2);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("cont_first_m0", m0_gnt, 1);
    chk("cont_first_m1", m1_gnt, 0);
    tick();
    drive(0, 1'b0, 1'b1, 8'h01, 32'h1);
    @(negedge clk);
    chk("cont_issue_m1", m1_gnt, 0);
    tick();
    @(negedge clk);
    chk("cont_second_m1", m1_gnt, 1);
    chk("cont_second_m0", m0_gnt, 0);
    tick();
    drive(1, 1'b0, 1'b1, 8'h02, 32'h2);

    // Continuous contention alternates m0, m1, m0, m1
    repeat (3) tick();
    drive(0, 1'b1, 1'b1, 8'h03, 32'h3);
    drive(1, 1'b1, 1'b1, 8'h04, 32'h4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("alt_m0", m0_gnt, (k % 4 == 0));
      chk("alt_m1", m1_gnt, (k % 4 == 2));
      tick();
    end
    drive(0, 1'b0, 1'b1, 8'h03, 32'h3);
    drive(1, 1'b0, 1'b1, 8'h04, 32'h4);

    // m0 write then read-back
    tick();
    request(0, 1'b1, 8'h10, 32'hDEADBEEF, gw);
    @(negedge clk);
    chk("wr_start", ram_start, 1);
    chk("wr_we", ram_we, 1);
    chk("wr_adr", ram_adr, 8'h10);
    request(0, 1'b0, 8'h10, 32'h0, g);
    chk("rd_gnt_gap", g - gw, 2);
    at_cycle(g + 3);
    chk("rd_m0_rvalid", m0_rvalid, 1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);

    // Read return goes only to m1
    request(1, 1'b0, 8'h02, 32'h0, g);
    at_cycle(g + 3);
    chk("route_m1_rvalid", m1_rvalid, 1);
    chk("route_m1_rdata", m1_rdata, 32'h2);
    chk("route_m0_rvalid", m0_rvalid, 0);
    chk("route_m0_rdata", m0_rdata, 32'hDEADBEEF);

    // Simultaneous write (m0) and read (m1) of the same address
    tick();
    fork
      request(0, 1'b1, 8'h05, 32'h55, g);
      request(1, 1'b0, 8'h05, 32'h0, g2);
    join
    chk("raw_order", g2 - g, 2);
    at_cycle(g2 + 3);
    chk("raw_m1_rdata", m1_rdata, 32'h55);

    // Reset during RDWAIT drops the read
    tick();
    request(1, 1'b0, 8'h04, 32'h0, g);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    tick();
    rst = 1'b0;
    drive(1, 1'b1, 1'b0, 8'h02, 32'h0);
    @(negedge clk);
    chk("mid_regnt", m1_gnt, 1);
    chk("mid_no_rvalid", m1_rvalid, 0);
    chk("mid_busy_after", busy, 0);
    chk("mid_rdata_cleared", m1_rdata, 0);
    gr = cyc;
    tick();
    drive(1, 1'b0, 1'b0, 8'h02, 32'h0);
    at_cycle(gr + 3);
    chk("mid_new_rvalid", m1_rvalid, 1);
    chk("mid_new_rdata", m1_rdata, 32'h2);

    // RD_LAT=3 instance: write then read, timing checked cycle by cycle
    tick();
    b_m0_req = 1; b_m0_we = 1; b_m0_adr = 8'h20; b_m0_din = 32'hCAFEF00D;
    @(negedge clk);
    chk("b_wr_gnt", b_m0_gnt, 1);
    tick();
    b_m0_req = 0;
    @(negedge clk);
    chk("b_wr_start", b_ram_start, 1);
    chk("b_wr_we", b_ram_we, 1);
    chk("b_wr_adr", b_ram_adr, 8'h20);
    chk("b_wr_din", b_ram_din, 32'hCAFEF00D);
    chk("b_wr_busy", b_busy, 1);
    tick();
    b_m0_req = 1; b_m0_we = 0;
    @(negedge clk);
    chk("b_rd_gnt", b_m0_gnt, 1);
    tick();
    b_m0_req = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("b_rd_start", b_ram_start, (k == 1));
      chk("b_rd_busy", b_busy, (k <= 4));
      chk("b_rd_rvalid", b_m0_rvalid, (k == 5));
      chk("b_m1_rvalid", b_m1_rvalid, 0);
      chk("b_m1_gnt", b_m1_gnt, 0);
      if (k == 5) begin
        chk("b_rd_rdata", b_m0_rdata, 32'hCAFEF00D);
        chk("b_m1_rdata", b_m1_rdata, 0);
      end
      tick();
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer in front of the single-port `ram` block (8-bit address, 32-bit data). It accepts independent read/write commands from two requesters, serialises them onto the RAM's `start`/`we`/`adr`/`din` interface and returns read data to the requester that issued the read. It sits between the datapath masters and the `ram` instance, and is the only block that drives the RAM's control inputs.

## Interface
- `AW`, 8, address width (matches `ram` `adr`)
- `DW`, 32, data width (matches `ram` `din`/`dout`)
- `RD_LAT`, 1, RAM read latency in cycles from the `start` cycle to valid `dout`; legal range 1–4
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `m0_req`  in  1  requester 0 command request; held until `m0_gnt`
- `m0_we`  in  1  requester 0: 1 = write, 0 = read
- `m0_adr`  in  AW  requester 0 address
- `m0_din`  in  DW  requester 0 write data
- `m0_gnt`  out  1  one-cycle grant; the command is accepted in this cycle
- `m0_rvalid`  out  1  one-cycle pulse; `m0_rdata` is valid
- `m0_rdata`  out  DW  read data for requester 0
- `m1_*`  same set as `m0_*`, for requester 1
- `busy`  out  1  high in every state except IDLE
- `ram_start`  out  1  to `ram.start`; one-cycle access strobe
- `ram_we`  out  1  to `ram.we`
- `ram_adr`  out  AW  to `ram.adr`
- `ram_din`  out  DW  to `ram.din`
- `ram_dout`  in  DW  from `ram.dout`

## Operation
- The FSM has three states: IDLE, ISSUE and RDWAIT.
- **IDLE**
  - If any `mX_req` is high, grant exactly one requester: `mX_gnt` is high combinationally in that cycle.
  - Latch the winner's `we`/`adr`/`din` and its index.
  - Next state is ISSUE.
  - With no request, stay in IDLE.
- **ISSUE**
  - Drive `ram_start`=1 with the latched command. All `ram_*` outputs are registered.
  - Write: next state is IDLE.
  - Read: load the wait counter with `RD_LAT` and go to RDWAIT.
- **RDWAIT**
  - Decrement the counter each cycle.
  - When it reaches 0, capture `ram_dout` into the winner's `rdata` register and pulse that winner's `rvalid` in the following cycle.
  - Next state is IDLE.
- **Arbitration**
  - Round-robin with a 1-bit priority pointer, reset to requester 0.
  - After a grant, the pointer moves to the other requester.
  - A single requester is always granted, regardless of the pointer.
  - When both requesters assert `req` in the same IDLE cycle, the pointer decides the winner.
- **Request rules**
  - A requester keeps `req` and its command stable until it sees `gnt`.
  - It drops `req`, or presents a new command, in the cycle after `gnt`.
  - A `req` dropped before `gnt` is simply not served; it is not an error.
- **Ordering and outputs**
  - Accesses complete in grant order.
  - A read granted after a write to the same address returns the new data.
  - Outside the ISSUE cycle, `ram_start` is 0 and `ram_we` is 0.
  - `ram_adr`/`ram_din` hold their last values.
  - `mX_rdata` holds its value until the next read for that requester completes.
- **Reset values**
  - FSM = IDLE; pointer = 0; counter = 0.
  - `ram_start`, `ram_we` = 0; `ram_adr`, `ram_din` = 0.
  - `mX_gnt`, `mX_rvalid`, `busy` = 0; `mX_rdata` = 0.
- **Reset during operation**
  - A reset in any state returns the FSM to IDLE on the next edge.
  - A pending read is dropped: no `rvalid` is issued for it.
  - A `ram_start` pulse already registered for the reset edge does not occur.

## Timing
- Grant cycle is G.
- ISSUE (`ram_start`=1) is at G+1.
- Write: back in IDLE at G+2. The next grant is possible at G+2, so writes sustain one per 2 cycles.
- Read: RDWAIT spans G+2 … G+1+RD_LAT; `ram_dout` is sampled at the end of cycle G+1+RD_LAT.
- Read: `rvalid` is high at G+2+RD_LAT, which is also an IDLE cycle, so a new grant may coincide with it. With `RD_LAT`=1 this gives `rvalid` at G+3 and one read per 3 cycles.
- `gnt` is never asserted outside IDLE, and never to both requesters in the same cycle.
- `busy` is high from G+1 until the cycle before the return to IDLE.

## Test plan
- **Reset and idle:** after `rst` is held 2 cycles, all outputs are 0. With no requests for 10 cycles, `ram_start` stays 0 and `busy` stays 0.
- **Single write then read (m0):**
  - Write `adr`=8'h10, `din`=32'hDEADBEEF: `m0_gnt` at G; `ram_start`=1, `ram_we`=1, `ram_adr`=8'h10 at G+1.
  - Then read 8'h10: `m0_rvalid`=1 with `m0_rdata`=32'hDEADBEEF exactly 3 cycles after its grant (`RD_LAT`=1).
- **Simultaneous contention:**
  - m0 and m1 both hold write requests from reset (m0→8'h01/32'h1, m1→8'h02/32'h2): m0 is granted first, m1 is granted 2 cycles later.
  - Holding both requests continuously alternates grants m0, m1, m0, m1.
- **Read return routing:** m1 reads 8'h02 while m0 waits. Only `m1_rvalid` pulses, with `m1_rdata`=32'h2; `m0_rvalid` stays 0 and `m0_rdata` is unchanged.
- **`RD_LAT`=3 build:** a read is granted at G; `ram_start` at G+1; `rvalid` at G+5. `busy` is high G+1…G+4.
- **Reset mid-read:** assert `rst` during RDWAIT. No `rvalid` follows, the FSM is in IDLE the cycle after reset is released, and a new m1 request is granted in that cycle.
